// File: rtl/demux_stream_router_if.sv
// -----------------------------------------------------------------------------
// demux_stream_router_if
//   Bundles the upstream valid/ready word stream and the NUM_CH downstream
//   valid/ready channels of the stream demultiplexer.
//
//   Upstream   : in_valid, in_ready, in_data[DATA_W], in_sel[SEL_W]
//   Downstream : out_valid[NUM_CH], out_ready[NUM_CH],
//                out_data[NUM_CH*DATA_W] (channel k at [k*DATA_W +: DATA_W])
//
//   master : the environment (producer + consumers)
//   slave  : the router
// -----------------------------------------------------------------------------
interface demux_stream_router_if #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic [SEL_W-1:0]           in_sel;
  logic [NUM_CH-1:0]          out_valid;
  logic [NUM_CH-1:0]          out_ready;
  logic [NUM_CH*DATA_W-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_stream_router.sv
// -----------------------------------------------------------------------------
// demux_stream_router
//   Registered 1-to-NUM_CH stream demultiplexer. Each accepted word is written
//   into a one-entry register of the channel named by its select and presented
//   there one clock later. Each channel drains independently under its own
//   ready. Words whose select names no channel are accepted, discarded and
//   counted in a saturating drop counter.
//
//   Ports
//     clk        : single clock, rising edge
//     rst        : synchronous, active-high reset
//     bus        : demux_stream_router_if.slave (upstream + NUM_CH channels)
//     drop_count : saturating count of words dropped for out-of-range select
// -----------------------------------------------------------------------------
module demux_stream_router #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  demux_stream_router_if.slave   bus,
  output logic [CNT_W-1:0]       drop_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic [NUM_CH-1:0]        vld_p1;
  logic [NUM_CH*DATA_W-1:0] data_p1;
  logic [CNT_W-1:0]         drop_cnt;

  logic [NUM_CH-1:0]        sel_hit;
  logic [NUM_CH-1:0]        load;
  logic                     in_range;
  logic                     sel_free;
  logic                     in_ready_c;
  logic                     accept;
  logic                     drop;

  // ---- Stage p0: select decode and upstream handshake ----------------------
  // The decode loop doubles as the range check, so an out-of-range select
  // never indexes past the channel vectors.
  always_comb begin
    sel_hit  = '0;
    sel_free = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_hit[k] = 1'b1;
        // Free if empty, or if its word leaves this same cycle.
        sel_free   = ~vld_p1[k] | bus.out_ready[k];
      end
    end
  end

  assign in_range   = |sel_hit;
  // Out-of-range words are always taken so they cannot wedge the stream.
  assign in_ready_c = ~rst & (~in_range | sel_free);
  assign accept     = bus.in_valid & in_ready_c;
  assign load       = sel_hit & {NUM_CH{accept}};
  assign drop       = accept & ~in_range;

  // ---- Stage p1: per-channel output registers and drop counter -------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= '0;
      data_p1  <= '0;
      drop_cnt <= '0;
    end else begin
      // A load wins over a drain on the same channel, giving back-to-back
      // throughput; a stalled channel simply holds.
      vld_p1 <= load | (vld_p1 & ~bus.out_ready);
      for (int k = 0; k < NUM_CH; k++) begin
        if (load[k]) begin
          data_p1[k*DATA_W +: DATA_W] <= bus.in_data;
        end
      end
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign drop_count    = drop_cnt;

endmodule

// File: tb/tb_demux_stream_router.sv
// -----------------------------------------------------------------------------
// tb_demux_stream_router
//   Two router instances: A (16 channels, 8-bit counter) and B (12 channels,
//   2-bit counter, so selects 12..15 are dropped). A behavioural model of the
//   channel registers and drop counter predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_demux_stream_router;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_stream_router_if #(.NUM_CH(16), .DATA_W(8), .SEL_W(4)) ifa ();
  demux_stream_router_if #(.NUM_CH(12), .DATA_W(8), .SEL_W(4)) ifb ();
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  demux_stream_router #(.NUM_CH(16), .DATA_W(8), .SEL_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave), .drop_count(cnt_a));
  demux_stream_router #(.NUM_CH(12), .DATA_W(8), .SEL_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave), .drop_count(cnt_b));

  int errors = 0;
  int checks = 0;

  // Stimulus per instance
  logic        iv   [2];
  logic [3:0]  isel [2];
  logic [7:0]  idat [2];
  logic [15:0] ordy [2];

  // Reference model per instance
  int          nch  [2] = '{16, 12};
  int          cmax [2] = '{255, 3};
  logic [7:0]  m_data [2][16];
  bit          m_vld  [2][16];
  int          m_cnt  [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    ifa.in_valid  = iv[0];
    ifa.in_sel    = isel[0];
    ifa.in_data   = idat[0];
    ifa.out_ready = ordy[0];
    ifb.in_valid  = iv[1];
    ifb.in_sel    = isel[1];
    ifb.in_data   = idat[1];
    ifb.out_ready = ordy[1][11:0];
  endtask

  function automatic bit exp_ready(input int i);
    if (rst) return 1'b0;
    if (int'(isel[i]) >= nch[i]) return 1'b1;
    return !m_vld[i][isel[i]] || ordy[i][isel[i]];
  endfunction

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; isel[i] = '0; idat[i] = '0; ordy[i] = '1;
    end
  endtask

  // One clock: check in_ready before the edge, advance the model, then
  // check every registered output after the edge.
  task automatic tick();
    logic [127:0] ed;
    logic [15:0]  ev;
    bit           r;
    apply();
    #1;
    for (int i = 0; i < 2; i++) begin
      r = exp_ready(i);
      if (i == 0) chk("in_ready_a", 128'(ifa.in_ready), 128'(r));
      else        chk("in_ready_b", 128'(ifb.in_ready), 128'(r));
      if (rst) begin
        for (int k = 0; k < 16; k++) begin m_vld[i][k] = 0; m_data[i][k] = '0; end
        m_cnt[i] = 0;
      end else begin
        for (int k = 0; k < nch[i]; k++)
          if (m_vld[i][k] && ordy[i][k]) m_vld[i][k] = 0;
        if (iv[i] && r) begin
          if (int'(isel[i]) < nch[i]) begin
            m_data[i][isel[i]] = idat[i];
            m_vld[i][isel[i]]  = 1;
          end else if (m_cnt[i] < cmax[i]) begin
            m_cnt[i]++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      ev = '0; ed = '0;
      for (int k = 0; k < nch[i]; k++) begin
        ev[k] = m_vld[i][k];
        ed[k*8 +: 8] = m_data[i][k];
      end
      if (i == 0) begin
        chk("out_valid_a", 128'(ifa.out_valid), 128'(ev));
        chk("out_data_a", 128'(ifa.out_data), ed);
        chk("drop_count_a", 128'(cnt_a), 128'(m_cnt[0]));
      end else begin
        chk("out_valid_b", 128'(ifb.out_valid), 128'(ev));
        chk("out_data_b", 128'(ifb.out_data), ed);
        chk("drop_count_b", 128'(cnt_b), 128'(m_cnt[1]));
      end
    end
  endtask

  logic [1:0] drop_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [3:0] drop_sel [5] = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd12};

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      for (int k = 0; k < 16; k++) begin m_vld[i][k] = 0; m_data[i][k] = '0; end
    end
    idle_all();
    // Arbitrary state before reset; the model's reset clears it.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Sweep all channels of A with every consumer ready.
    for (int i = 0; i < 16; i++) begin
      iv[0] = 1'b1; isel[0] = 4'(i); idat[0] = 8'hA0 + 8'(i);
      tick();
      chk("sweep_vld", 128'(ifa.out_valid[i]), 128'(1));
      chk("sweep_data", 128'(ifa.out_data[i*8 +: 8]), 128'(8'hA0 + 8'(i)));
    end
    idle_all();
    tick();

    // Backpressure on channel 3; channel 5 keeps flowing.
    ordy[0] = 16'hFFF7;
    iv[0] = 1'b1; isel[0] = 4'd3; idat[0] = 8'h11;
    tick();
    idat[0] = 8'h22;
    tick();
    chk("bp_hold", 128'(ifa.out_data[3*8 +: 8]), 128'(8'h11));
    isel[0] = 4'd5; idat[0] = 8'h55;
    tick();
    chk("bp_ch5", 128'(ifa.out_data[5*8 +: 8]), 128'(8'h55));
    chk("bp_ch3_vld", 128'(ifa.out_valid[3]), 128'(1));
    isel[0] = 4'd3; idat[0] = 8'h22; ordy[0] = 16'hFFFF;
    tick();
    chk("bp_release", 128'(ifa.out_data[3*8 +: 8]), 128'(8'h22));
    idle_all();
    tick();

    // Back-to-back streaming on channel 0.
    for (int i = 0; i < 8; i++) begin
      iv[0] = 1'b1; isel[0] = 4'd0; idat[0] = 8'(i + 1);
      tick();
      chk("stream_data", 128'(ifa.out_data[7:0]), 128'(i + 1));
    end
    idle_all();
    tick();

    // Out-of-range selects on B saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      iv[1] = 1'b1; isel[1] = drop_sel[i]; idat[1] = 8'(i);
      tick();
      chk("drop_seq", 128'(cnt_b), 128'(drop_exp[i]));
    end
    idle_all();

    // Reset mid-operation with a stalled word and a nonzero drop count.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    iv[1] = 1'b1; isel[1] = 4'd12;
    ordy[0] = 16'hFF7F; iv[0] = 1'b1; isel[0] = 4'd7; idat[0] = 8'h77;
    tick();
    iv[0] = 1'b0;
    tick();
    chk("pre_rst_ch7", 128'(ifa.out_data[7*8 +: 8]), 128'(8'h77));
    chk("pre_rst_cnt", 128'(cnt_b), 128'(2));
    rst = 1'b1;
    iv[0] = 1'b1; isel[0] = 4'd7; idat[0] = 8'h99;
    iv[1] = 1'b1; isel[1] = 4'd2; idat[1] = 8'h42;
    tick();
    rst = 1'b0;
    idle_all();
    chk("post_rst_vld", 128'(ifa.out_valid), 128'(0));
    chk("post_rst_data", 128'(ifa.out_data), 128'(0));
    chk("post_rst_cnt", 128'(cnt_b), 128'(0));
    tick();

    // Idle: selects and readies wander, nothing is presented.
    for (int i = 0; i < 16; i++) begin
      iv[0] = 1'b0; iv[1] = 1'b0;
      isel[0] = 4'(i); isel[1] = 4'(15 - i);
      idat[0] = 8'($urandom); idat[1] = 8'($urandom);
      ordy[0] = 16'($urandom); ordy[1] = 16'($urandom);
      tick();
    end

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 2; i++) begin
        iv[i]   = ($urandom_range(0, 3) != 0);
        isel[i] = 4'($urandom);
        idat[i] = 8'($urandom);
        ordy[i] = 16'($urandom) | 16'($urandom);
      end
      tick();
    end
    rst = 1'b0;
    idle_all();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_stream_router.md
Name: demux_stream_router

Overview:
Parametrised 1-to-NUM_CH stream demultiplexer with valid/ready handshake. Each output channel has a one-entry register. The select travels with the data. Selects outside the channel range are accepted, discarded and counted. This block is the registered, back-pressured successor of the combinational 1:16 demux, and sits between a single upstream producer and NUM_CH independent consumers.

Parameters:
NUM_CH, 16, number of output channels (2..16)
DATA_W, 8, width of each data word
SEL_W, 4, select width; must satisfy 2**SEL_W >= NUM_CH
CNT_W, 8, width of the saturating drop counter

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept the presented word this cycle
in_data  input  DATA_W  upstream data word
in_sel  input  SEL_W  destination channel of the presented word
out_valid  output  NUM_CH  per-channel output valid, bit k = channel k
out_ready  input  NUM_CH  per-channel consumer ready
out_data  output  NUM_CH*DATA_W  flattened outputs; channel k at bits [k*DATA_W +: DATA_W]
drop_count  output  CNT_W  number of words dropped for an out-of-range select

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values (state after any clk edge with rst=1):
  - out_valid = 0
  - out_data = 0
  - drop_count = 0
  - in_ready = 0 while rst=1
- accept = in_valid & in_ready. in_data and in_sel are ignored when in_valid=0.
- in_ready is combinational and depends only on in_sel, out_valid, out_ready and rst:
  - rst=1: 0
  - in_sel >= NUM_CH: 1
  - otherwise: ~out_valid[in_sel] | out_ready[in_sel]
- Accept to channel k (in_sel < NUM_CH):
  - next cycle: out_data slice k = in_data and out_valid[k] = 1
  - latency is one clock
- Channel k drain (out_valid[k] & out_ready[k]) with no accept to k in the same cycle: out_valid[k] clears next cycle. The data slice keeps its last value.
- Simultaneous drain and accept on k: out_valid[k] stays 1 and the slice loads the new word. Per-channel throughput is one word per cycle with no bubble.
- Stall: while out_valid[k] & ~out_ready[k], slice k and out_valid[k] hold constant.
- Channel independence:
  - Channels are fully independent.
  - Any number of channels may drain in the same cycle.
  - At most one channel loads per cycle.
  - A stalled channel never blocks accepts to other channels.
- Out-of-range select (in_sel >= NUM_CH, possible only when NUM_CH < 2**SEL_W):
  - the word is accepted and discarded
  - no out_valid bit changes
  - drop_count increments by 1, saturating at 2**CNT_W-1 (no wrap)
- Reset mid-operation discards all buffered words and clears drop_count. Outputs are valid again only after new accepts.
- No internal state machine beyond the per-channel valid flags. Total state is NUM_CH*(DATA_W+1)+CNT_W flops.
- Upstream is expected to hold in_data and in_sel stable while in_valid & ~in_ready. Correctness of accepted words does not depend on this.

Test Plan:
1. Sweep: reset, all out_ready=1, in_valid=1, in_sel=0..15 on consecutive cycles, in_data=0xA0+i -> in_ready=1 every cycle; one cycle after each accept out_valid[i]=1 and slice i=0xA0+i; 16 words in 16 cycles.
2. Backpressure: out_ready[3]=0; send 0x11 then 0x22 to ch3 -> 0x11 accepted, out_valid[3]=1 holding 0x11, in_ready=0 for 0x22; meanwhile sel=5 data 0x55 is accepted and out_data ch5=0x55; raise out_ready[3] -> 0x22 accepted that cycle, next cycle out_valid[3]=1 and slice 3=0x22.
3. Streaming: ch0 with out_ready[0]=1, data 0x01..0x08 back-to-back -> out_valid[0] high for 8 consecutive cycles showing 0x01..0x08 in order, in_ready never drops.
4. Drops: instance NUM_CH=12, SEL_W=4, CNT_W=2; send sel=12,13,14,15,12 -> in_ready=1 each cycle, out_valid stays 0, drop_count = 1,2,3,3,3 (saturates at 3).
5. Reset mid-operation: ch7 holding 0x77 with out_ready[7]=0 and drop_count=2; assert rst for 1 cycle -> in_ready=0 during rst; next cycle out_valid=0, out_data=0, drop_count=0.
6. Idle: in_valid=0 while in_sel toggles 0..15 and out_ready toggles -> no change to out_valid, out_data or drop_count.
